// File: rtl/video_raster_gen_if.sv
// Raster generator bundle: CPU-side timing/IRQ config in, counters, decodes and strobes out.
interface video_raster_gen_if #(
   parameter int HW   = 9,
   parameter int VW   = 9,
   parameter int NINT = 2
);
   logic                 ce;
   logic [HW-1:0]        h_total, h_sync_beg, h_sync_end, h_blank_end, h_pix_beg, h_pix_end;
   logic [VW-1:0]        v_total, v_sync_beg, v_sync_end, v_blank_end, v_pix_beg, v_pix_end;
   logic                 sync_pol;
   logic [NINT*HW-1:0]   int_h;
   logic [NINT*VW-1:0]   int_v;
   logic [NINT-1:0]      int_en;
   logic [NINT-1:0]      int_ack;
   logic [HW-1:0]        hcount;
   logic [VW-1:0]        vcount;
   logic                 hsync, vsync, csync, hblank, vblank, hpix, vpix;
   logic                 line_start, frame_start;
   logic [NINT-1:0]      int_pend;
   logic                 int_any;
   logic [4:0]           frame_cnt;
   logic                 field;

   modport master (
      output ce, h_total, h_sync_beg, h_sync_end, h_blank_end, h_pix_beg, h_pix_end,
             v_total, v_sync_beg, v_sync_end, v_blank_end, v_pix_beg, v_pix_end,
             sync_pol, int_h, int_v, int_en, int_ack,
      input  hcount, vcount, hsync, vsync, csync, hblank, vblank, hpix, vpix,
             line_start, frame_start, int_pend, int_any, frame_cnt, field
   );

   modport slave (
      input  ce, h_total, h_sync_beg, h_sync_end, h_blank_end, h_pix_beg, h_pix_end,
             v_total, v_sync_beg, v_sync_end, v_blank_end, v_pix_beg, v_pix_end,
             sync_pol, int_h, int_v, int_en, int_ack,
      output hcount, vcount, hsync, vsync, csync, hblank, vblank, hpix, vpix,
             line_start, frame_start, int_pend, int_any, frame_cnt, field
   );
endinterface

// File: rtl/video_raster_gen.sv
// Programmable raster timing generator: frame-boundary shadowed timing, decodes, strobes, raster IRQs.
// Half-line interlace (odd field one line longer, vsync offset by half a line) with `define RASTER_INTERLACE_EN.
module video_raster_gen #(
   parameter int HW   = 9,
   parameter int VW   = 9,
   parameter int NINT = 2
) (
   input  logic              clk,
   input  logic              rst,
   video_raster_gen_if.slave bus
);
   typedef struct packed {
      logic [HW-1:0] h_total;
      logic [HW-1:0] h_sync_beg;
      logic [HW-1:0] h_sync_end;
      logic [HW-1:0] h_blank_end;
      logic [HW-1:0] h_pix_beg;
      logic [HW-1:0] h_pix_end;
      logic [VW-1:0] v_total;
      logic [VW-1:0] v_sync_beg;
      logic [VW-1:0] v_sync_end;
      logic [VW-1:0] v_blank_end;
      logic [VW-1:0] v_pix_beg;
      logic [VW-1:0] v_pix_end;
   } timing_t;

   timing_t         live, shd_q;
   logic [HW-1:0]   hcount_q, hcount_d;
   logic [VW-1:0]   vcount_q, vcount_d;
   logic            hs_q, vs_q, csync_q, hblank_q, vblank_q, hpix_q, vpix_q;
   logic            hs_d, vs_d;
   logic            line_start_q, frame_start_q, load_pend_q, field_q, odd_field;
   logic [4:0]      frame_cnt_q;
   logic [NINT-1:0] int_pend_q, int_pend_d, int_hit;
   logic [VW:0]     vlast;
   logic            h_wrap, v_wrap, frame_wrap;

   // Half-open window; end <= beg never matches.
   function automatic logic win_h(input logic [HW-1:0] c, input logic [HW-1:0] b, input logic [HW-1:0] e);
      return (e > b) && (c >= b) && (c < e);
   endfunction

   function automatic logic win_v(input logic [VW-1:0] c, input logic [VW-1:0] b, input logic [VW-1:0] e);
      return (e > b) && (c >= b) && (c < e);
   endfunction

   assign live = {bus.h_total, bus.h_sync_beg, bus.h_sync_end, bus.h_blank_end, bus.h_pix_beg, bus.h_pix_end,
                  bus.v_total, bus.v_sync_beg, bus.v_sync_end, bus.v_blank_end, bus.v_pix_beg, bus.v_pix_end};

`ifdef RASTER_INTERLACE_EN
   assign odd_field = field_q;
`else
   assign odd_field = 1'b0;
`endif

   // One extra bit so the odd-field line count cannot overflow the compare.
   assign vlast      = {1'b0, shd_q.v_total} + {{VW{1'b0}}, odd_field};
   assign h_wrap     = hcount_q >= shd_q.h_total;
   assign v_wrap     = {1'b0, vcount_q} >= vlast;
   assign frame_wrap = bus.ce & h_wrap & v_wrap;

   always_comb begin
      hcount_d = h_wrap ? '0 : hcount_q + HW'(1);
      vcount_d = vcount_q;
      if (h_wrap) begin
         vcount_d = v_wrap ? '0 : vcount_q + VW'(1);
      end
   end

   assign hs_d = win_h(hcount_q, shd_q.h_sync_beg, shd_q.h_sync_end);

`ifdef RASTER_INTERLACE_EN
   logic [HW-1:0] h_half;
   logic          vs_after_beg, vs_before_end;

   // Odd field: vsync edges sit mid-line on the sync-begin and sync-end lines.
   assign h_half        = shd_q.h_total >> 1;
   assign vs_after_beg  = (vcount_q > shd_q.v_sync_beg) ||
                          ((vcount_q == shd_q.v_sync_beg) && (hcount_q >= h_half));
   assign vs_before_end = (vcount_q < shd_q.v_sync_end) ||
                          ((vcount_q == shd_q.v_sync_end) && (hcount_q < h_half));
   assign vs_d = odd_field ? ((shd_q.v_sync_end > shd_q.v_sync_beg) & vs_after_beg & vs_before_end)
                           : win_v(vcount_q, shd_q.v_sync_beg, shd_q.v_sync_end);
`else
   assign vs_d = win_v(vcount_q, shd_q.v_sync_beg, shd_q.v_sync_end);
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NINT; gi++) begin : g_int
         assign int_hit[gi] = bus.ce & bus.int_en[gi] &
                              (hcount_q == bus.int_h[gi*HW +: HW]) &
                              (vcount_q == bus.int_v[gi*VW +: VW]);
      end
   endgenerate

   // A hit in the same clock as its ack keeps the flag set.
   assign int_pend_d = int_hit | (int_pend_q & ~bus.int_ack);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shd_q         <= '0;
         hcount_q      <= '0;
         vcount_q      <= '0;
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         csync_q       <= 1'b1;
         hblank_q      <= 1'b0;
         vblank_q      <= 1'b0;
         hpix_q        <= 1'b0;
         vpix_q        <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         int_pend_q    <= '0;
         frame_cnt_q   <= '0;
         field_q       <= 1'b0;
         load_pend_q   <= 1'b1;
      end else begin
         line_start_q  <= bus.ce & h_wrap;
         frame_start_q <= frame_wrap;
         int_pend_q    <= int_pend_d;
         load_pend_q   <= 1'b1;
         if (bus.ce) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            csync_q  <= ~(hs_d ^ vs_d);
            hblank_q <= hcount_q < shd_q.h_blank_end;
            vblank_q <= vcount_q < shd_q.v_blank_end;
            hpix_q   <= win_h(hcount_q, shd_q.h_pix_beg, shd_q.h_pix_end);
            vpix_q   <= win_v(vcount_q, shd_q.v_pix_beg, shd_q.v_pix_end);
         end
         if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 5'd1;
`ifdef RASTER_INTERLACE_EN
            field_q <= ~field_q;
`endif
            if (load_pend_q) begin
               shd_q <= live;
            end
         end
      end
   end

   assign bus.hcount      = hcount_q;
   assign bus.vcount      = vcount_q;
   assign bus.hsync       = hs_q ^ bus.sync_pol;
   assign bus.vsync       = vs_q ^ bus.sync_pol;
   assign bus.csync       = csync_q;
   assign bus.hblank      = hblank_q;
   assign bus.vblank      = vblank_q;
   assign bus.hpix        = hpix_q;
   assign bus.vpix        = vpix_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.int_pend    = int_pend_q;
   assign bus.int_any     = |int_pend_q;
   assign bus.frame_cnt   = frame_cnt_q;
   assign bus.field       = field_q;
endmodule

// File: tb/tb_video_raster_gen.sv
// Scoreboard bench for video_raster_gen: a behavioural raster model queues the expected outputs per clock.
module tb_video_raster_gen;
   localparam int HW   = 9;
   localparam int VW   = 9;
   localparam int NINT = 2;
`ifdef RASTER_INTERLACE_EN
   localparam bit INTERLACE = 1'b1;
`else
   localparam bit INTERLACE = 1'b0;
`endif

   logic clk;
   logic rst;

   video_raster_gen_if #(.HW(HW), .VW(VW), .NINT(NINT)) vif ();

   video_raster_gen #(.HW(HW), .VW(VW), .NINT(NINT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];

   // model state
   int m_h, m_v, m_fcnt;
   int s_ht, s_hsb, s_hse, s_hbe, s_hpb, s_hpe, s_vt, s_vsb, s_vse, s_vbe, s_vpb, s_vpe;
   bit m_hs, m_vs, m_cs, m_hb, m_vb, m_hp, m_vp, m_ls, m_fs, m_fld, m_last_odd;
   logic [NINT-1:0] m_pend;

   // measurement state
   int cyc, last_ls, ls_period, ls_cnt, lines_last, hs_cnt, hs_last, fcnt_diff, hpix_cnt, cs_bad, ce_phase;
   logic [4:0] fcnt_prev;
   bit hit0_seen, auto_ack0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_h = 0; m_v = 0; m_fcnt = 0;
      s_ht = 0; s_hsb = 0; s_hse = 0; s_hbe = 0; s_hpb = 0; s_hpe = 0;
      s_vt = 0; s_vsb = 0; s_vse = 0; s_vbe = 0; s_vpb = 0; s_vpe = 0;
      {m_hs, m_vs, m_hb, m_vb, m_hp, m_vp, m_ls, m_fs, m_fld, m_last_odd} = '0;
      m_cs = 1'b1;
      m_pend = '0;
      last_ls = -1; ls_cnt = 0; hs_cnt = 0; ce_phase = 0;
   endtask

   task automatic load_shadow();
      s_ht  = int'(vif.h_total);     s_hsb = int'(vif.h_sync_beg); s_hse = int'(vif.h_sync_end);
      s_hbe = int'(vif.h_blank_end); s_hpb = int'(vif.h_pix_beg);  s_hpe = int'(vif.h_pix_end);
      s_vt  = int'(vif.v_total);     s_vsb = int'(vif.v_sync_beg); s_vse = int'(vif.v_sync_end);
      s_vbe = int'(vif.v_blank_end); s_vpb = int'(vif.v_pix_beg);  s_vpe = int'(vif.v_pix_end);
   endtask

   task automatic model_step(input bit ce_v, input logic [NINT-1:0] ack_v);
      int vlast, wdt, pos;
      bit hw, vw;
      logic [NINT-1:0] hit;
      vlast = s_vt + ((INTERLACE && m_fld) ? 1 : 0);
      hw = (m_h >= s_ht);
      vw = (m_v >= vlast);
      for (int i = 0; i < NINT; i++)
         hit[i] = ce_v && vif.int_en[i] && (m_h == int'(vif.int_h[i*HW +: HW])) &&
                  (m_v == int'(vif.int_v[i*VW +: VW]));
      if (hit[0]) hit0_seen = 1'b1;
      m_pend = hit | (m_pend & ~ack_v);
      m_ls = ce_v && hw;
      m_fs = m_ls && vw;
      if (ce_v) begin
         m_hs = (m_h >= s_hsb) && (m_h < s_hse);
         if (INTERLACE && m_fld) begin
            wdt  = s_ht + 1;
            pos  = m_v * wdt + m_h;
            m_vs = (pos >= s_vsb * wdt + s_ht / 2) && (pos < s_vse * wdt + s_ht / 2);
         end else begin
            m_vs = (m_v >= s_vsb) && (m_v < s_vse);
         end
         m_cs = !(m_hs ^ m_vs);
         m_hb = m_h < s_hbe;
         m_vb = m_v < s_vbe;
         m_hp = (m_h >= s_hpb) && (m_h < s_hpe);
         m_vp = (m_v >= s_vpb) && (m_v < s_vpe);
         if (hw) begin
            m_h = 0;
            m_v = vw ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
         if (m_fs) begin
            m_last_odd = INTERLACE && m_fld;
            m_fcnt = (m_fcnt + 1) % 32;
            if (INTERLACE) m_fld = !m_fld;
            load_shadow();
         end
      end
   endtask

   function automatic logic [63:0] exp_vec();
      return 64'({9'(m_h), 9'(m_v), m_hs ^ vif.sync_pol, m_vs ^ vif.sync_pol, m_cs, m_hb, m_vb, m_hp, m_vp,
                  m_ls, m_fs, m_pend, |m_pend, 5'(m_fcnt), m_fld});
   endfunction

   function automatic logic [63:0] dut_vec();
      return 64'({vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.csync, vif.hblank, vif.vblank, vif.hpix,
                  vif.vpix, vif.line_start, vif.frame_start, vif.int_pend, vif.int_any, vif.frame_cnt, vif.field});
   endfunction

   function automatic logic [63:0] rst_vec(input logic pol);
      return 64'({18'd0, pol, pol, 1'b1, 4'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0});
   endfunction

   task automatic tick(input bit ce_v, input logic [NINT-1:0] ack_v);
      vif.ce      = ce_v;
      vif.int_ack = ack_v;
      model_step(ce_v, ack_v);
      exp_q.push_back(exp_vec());
      @(posedge clk);
      #1;
      check_val("raster", dut_vec(), exp_q.pop_front());
      cyc++;
      if (ce_v && (vif.hsync ^ vif.sync_pol)) hs_cnt++;
      if (vif.hpix) hpix_cnt++;
      if (vif.csync !== ~(vif.vsync ^ vif.sync_pol)) cs_bad++;
      if (vif.line_start) begin
         if (last_ls >= 0) ls_period = cyc - last_ls;
         last_ls = cyc;
         ls_cnt++;
         hs_last = hs_cnt;
         hs_cnt = 0;
      end
      if (vif.frame_start) begin
         lines_last = ls_cnt;
         ls_cnt = 0;
         fcnt_diff = int'(5'(vif.frame_cnt - fcnt_prev));
         fcnt_prev = vif.frame_cnt;
      end
   endtask

   task automatic tick_auto();
      bit ce_v;
      logic [NINT-1:0] ack_v;
      ce_v = (ce_phase == 0);
      ce_phase = (ce_phase + 1) % 4;
      ack_v = '0;
      if (auto_ack0 && ce_v && vif.int_en[0] && (m_h == int'(vif.int_h[HW-1:0])) && (m_v == int'(vif.int_v[VW-1:0])))
         ack_v[0] = 1'b1;
      tick(ce_v, ack_v);
   endtask

   task automatic run_strobe(input bit frame, input int n, input string tag);
      int seen, budget;
      seen = 0;
      budget = 3000 * n;
      while (seen < n && budget > 0) begin
         tick_auto();
         if (frame ? vif.frame_start : vif.line_start) seen++;
         budget--;
      end
      if (seen < n) check_val(tag, 64'(seen), 64'(n));
   endtask

   task automatic run_until(input int h, input int v, input string tag);
      int budget;
      budget = 3000;
      while (!(m_h == h && m_v == v) && budget > 0) begin
         tick_auto();
         budget--;
      end
      if (budget == 0) check_val(tag, 64'({9'(m_h), 9'(m_v)}), 64'({9'(h), 9'(v)}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      vif.ce = 1'b0; vif.sync_pol = 1'b0; vif.int_en = '0; vif.int_ack = '0;
      vif.int_h = '0; vif.int_v = '0;
      vif.h_total = 9'd19; vif.h_sync_beg = 9'd3; vif.h_sync_end = 9'd7; vif.h_blank_end = 9'd4;
      vif.h_pix_beg = 9'd6; vif.h_pix_end = 9'd16;
      vif.v_total = 9'd9; vif.v_sync_beg = 9'd1; vif.v_sync_end = 9'd3; vif.v_blank_end = 9'd2;
      vif.v_pix_beg = 9'd3; vif.v_pix_end = 9'd8;
      cyc = 0; ls_period = 0; lines_last = 0; hs_last = 0; fcnt_diff = 0; hpix_cnt = 0; cs_bad = 0;
      fcnt_prev = '0; hit0_seen = 1'b0; auto_ack0 = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_state", dut_vec(), rst_vec(1'b0));
      rst = 1'b0;

      // nominal timing, ce every 4th clock
      run_strobe(1'b1, 3, "frame_timeout");
      check_val("line_period", 64'(ls_period), 64'(80));
      check_val("lines_per_frame", 64'(lines_last), 64'(10 + int'(m_last_odd)));
      check_val("hsync_width", 64'(hs_last), 64'(4));
      check_val("frame_cnt_step", 64'(fcnt_diff), 64'(1));

      // mid-frame v_total change only applies from the next frame
      run_until(0, 4, "pos_timeout");
      vif.v_total = 9'd5;
      run_strobe(1'b1, 1, "frame_timeout");
      check_val("old_vtotal_frame", 64'(lines_last), 64'(10 + int'(m_last_odd)));
      run_strobe(1'b1, 1, "frame_timeout");
      check_val("new_vtotal_frame", 64'(lines_last), 64'(6 + int'(m_last_odd)));

      // raster interrupts
      vif.int_h = {9'd5, 9'd10};
      vif.int_v = {9'd1, 9'd2};
      vif.int_en = 2'b11;
      auto_ack0 = 1'b1;
      hit0_seen = 1'b0;
      for (int i = 0; i < 3000 && !hit0_seen; i++) tick_auto();
      check_val("hit0_seen", 64'(hit0_seen), 64'(1));
      auto_ack0 = 1'b0;
      check_val("pend_set_wins", 64'(vif.int_pend[0]), 64'(1));
      check_val("int_any_on", 64'(vif.int_any), 64'(1));
      tick(1'b0, 2'b01);
      check_val("pend0_ack_clr", 64'(vif.int_pend[0]), 64'(0));
      check_val("pend1_sticky", 64'(vif.int_pend[1]), 64'(1));
      tick(1'b0, 2'b10);
      check_val("int_any_off", 64'(vif.int_any), 64'(0));
      run_until(6, 1, "pos_timeout");
      check_val("pend1_rehit", 64'(vif.int_pend[1]), 64'(1));
      vif.int_en = 2'b01;
      repeat (40) tick_auto();
      check_val("pend1_en_off", 64'(vif.int_pend[1]), 64'(1));
      tick(1'b0, 2'b11);
      vif.int_en = '0;

      // empty windows
      vif.h_pix_beg = 9'd12; vif.h_pix_end = 9'd12;
      vif.h_sync_beg = 9'd5; vif.h_sync_end = 9'd5;
      run_strobe(1'b1, 1, "frame_timeout");
      hpix_cnt = 0; cs_bad = 0;
      run_strobe(1'b1, 1, "frame_timeout");
      check_val("hpix_empty", 64'(hpix_cnt), 64'(0));
      check_val("hsync_empty", 64'(hs_last), 64'(0));
      check_val("csync_eq_nvs", 64'(cs_bad), 64'(0));

      // asynchronous reset mid-frame, new inputs picked up on restart
      vif.h_total = 9'd15;
      vif.sync_pol = 1'b1;
      run_until(13, 4, "pos_timeout");
      #2;
      rst = 1'b1;
      #1;
      check_val("reset_async", dut_vec(), rst_vec(1'b1));
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_strobe(1'b1, 1, "frame_timeout");
      check_val("restart_pos", 64'({vif.hcount, vif.vcount}), 64'(0));
      check_val("restart_fcnt", 64'(vif.frame_cnt), 64'(1));
      run_strobe(1'b0, 1, "line_timeout");
      check_val("restart_line_period", 64'(ls_period), 64'(64));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
